// File: rtl/vga_vram_arbiter.sv
// Single-port VRAM arbiter: display reads the front bank with absolute priority, writer fills the back bank.
// Optional macro VGA_ARB_STATS_EN adds the Wr_Stall_Cycles counter output.
module vga_vram_arbiter #(
   parameter int unsigned ADDR_W     = 19,
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned RD_LATENCY = 1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              Disp_Req,
   input  logic [ADDR_W-1:0] Disp_Addr,
   output logic [DATA_W-1:0] Disp_Data,
   output logic              Disp_Valid,
   input  logic              Wr_Req,
   input  logic [ADDR_W-1:0] Wr_Addr,
   input  logic [DATA_W-1:0] Wr_Data,
   output logic              Wr_Ack,
   input  logic              Swap_Req,
   input  logic              VBlank_Start,
   output logic              Swap_Pending,
   output logic              Front_Bank,
   output logic              Mem_En,
   output logic              Mem_WE,
   output logic [ADDR_W:0]   Mem_Addr,
   output logic [DATA_W-1:0] Mem_WData,
`ifdef VGA_ARB_STATS_EN
   output logic [15:0]       Wr_Stall_Cycles,
`endif
   input  logic [DATA_W-1:0] Mem_RData
);

   localparam int unsigned VP_W = RD_LATENCY + 1;

   logic            rd_grant;
   logic            wr_grant;
   logic            front_n;
   logic            pend_n;
   logic [VP_W-1:0] vpipe;

   // Display first, then writer; nothing is granted while in reset
   always_comb begin
      rd_grant = Disp_Req & ~RST;
      wr_grant = Wr_Req & ~Disp_Req & ~RST;
   end

   assign Wr_Ack = wr_grant;

   // Swap sequencing: a request arriving with VBlank_Start is applied at once
   always_comb begin
      front_n = Front_Bank;
      pend_n  = Swap_Pending;
      if (VBlank_Start && (Swap_Pending || Swap_Req)) begin
         front_n = ~Front_Bank;
         pend_n  = 1'b0;
      end else if (Swap_Req) begin
         pend_n  = 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         Front_Bank   <= 1'b0;
         Swap_Pending <= 1'b0;
         Mem_En       <= 1'b0;
         Mem_WE       <= 1'b0;
         Mem_Addr     <= '0;
         Mem_WData    <= '0;
         vpipe        <= '0;
      end else begin
         Front_Bank   <= front_n;
         Swap_Pending <= pend_n;
         Mem_En       <= rd_grant | wr_grant;
         Mem_WE       <= wr_grant;
         // Bank is taken from the pre-toggle Front_Bank, so accesses never straddle a swap
         if (rd_grant) begin
            Mem_Addr <= {Front_Bank, Disp_Addr};
         end else if (wr_grant) begin
            Mem_Addr  <= {~Front_Bank, Wr_Addr};
            Mem_WData <= Wr_Data;
         end
         vpipe <= {vpipe[VP_W-2:0], rd_grant};
      end
   end

   assign Disp_Valid = vpipe[VP_W-1];
   assign Disp_Data  = Disp_Valid ? Mem_RData : '0;

`ifdef VGA_ARB_STATS_EN
   // Saturating count of writer stall cycles, cleared each vertical blank
   always_ff @(posedge CLK) begin
      if (RST || VBlank_Start) begin
         Wr_Stall_Cycles <= 16'h0000;
      end else if (Wr_Req && !wr_grant && (Wr_Stall_Cycles != 16'hFFFF)) begin
         Wr_Stall_Cycles <= Wr_Stall_Cycles + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Scoreboard bench for vga_vram_arbiter: reference model pushes expected VRAM commands and display data, a monitor pops and compares.
module tb_vga_vram_arbiter;

   localparam int unsigned ADDR_W = 19;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned LAT    = 1;

   logic              CLK;
   logic              RST;
   logic              Disp_Req;
   logic [ADDR_W-1:0] Disp_Addr;
   logic [DATA_W-1:0] Disp_Data;
   logic              Disp_Valid;
   logic              Wr_Req;
   logic [ADDR_W-1:0] Wr_Addr;
   logic [DATA_W-1:0] Wr_Data;
   logic              Wr_Ack;
   logic              Swap_Req;
   logic              VBlank_Start;
   logic              Swap_Pending;
   logic              Front_Bank;
   logic              Mem_En;
   logic              Mem_WE;
   logic [ADDR_W:0]   Mem_Addr;
   logic [DATA_W-1:0] Mem_WData;
   logic [DATA_W-1:0] Mem_RData;
`ifdef VGA_ARB_STATS_EN
   logic [15:0]       Wr_Stall_Cycles;
`endif

   vga_vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(LAT)) dut (
      .CLK(CLK), .RST(RST),
      .Disp_Req(Disp_Req), .Disp_Addr(Disp_Addr), .Disp_Data(Disp_Data), .Disp_Valid(Disp_Valid),
      .Wr_Req(Wr_Req), .Wr_Addr(Wr_Addr), .Wr_Data(Wr_Data), .Wr_Ack(Wr_Ack),
      .Swap_Req(Swap_Req), .VBlank_Start(VBlank_Start),
      .Swap_Pending(Swap_Pending), .Front_Bank(Front_Bank),
      .Mem_En(Mem_En), .Mem_WE(Mem_WE), .Mem_Addr(Mem_Addr), .Mem_WData(Mem_WData),
`ifdef VGA_ARB_STATS_EN
      .Wr_Stall_Cycles(Wr_Stall_Cycles),
`endif
      .Mem_RData(Mem_RData)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      int          cyc;
      logic        we;
      logic [19:0] addr;
      logic [7:0]  wdata;
   } cmd_t;

   typedef struct {
      int         cyc;
      logic [7:0] data;
   } rd_t;

   cmd_t cmd_q[$];
   rd_t  rd_q[$];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   logic mon_en = 1'b0;
   logic rst_q  = 1'b0;

   // Reference state: m_* are the values visible this cycle, n_* after the next edge
   logic        m_front = 1'b0, n_front = 1'b0;
   logic        m_pend  = 1'b0, n_pend  = 1'b0;
   int          m_cnt   = 0,    n_cnt   = 0;
   logic        exp_ack = 1'b0;
   logic [7:0]  exp_mem [int];
   logic [7:0]  vram    [int];
   logic [7:0]  rdp     [LAT];

   function automatic logic [7:0] init_val(input logic [19:0] a);
      return a[7:0] ^ a[15:8] ^ {4'h5, a[19:16]};
   endfunction

   always @(posedge CLK) begin
      cyc   <= cyc + 1;
      rst_q <= RST;
   end

   // VRAM macro model with LAT-cycle registered read data
   always @(posedge CLK) begin
      if (Mem_En && Mem_WE) vram[int'(Mem_Addr)] = Mem_WData;
      for (int i = LAT - 1; i > 0; i--) rdp[i] = rdp[i-1];
      if (Mem_En && !Mem_WE)
         rdp[0] = vram.exists(int'(Mem_Addr)) ? vram[int'(Mem_Addr)] : init_val(Mem_Addr);
      else
         rdp[0] = 8'h00;
   end
   assign Mem_RData = rdp[LAT-1];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h want %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops expectations whenever the DUT presents a command or read data
   always @(negedge CLK) begin
      if (mon_en) begin
         cmd_t c;
         rd_t  r;
         chk("wr_ack", 32'(Wr_Ack), 32'(exp_ack));
         chk("front_bank", 32'(Front_Bank), 32'(m_front));
         chk("swap_pending", 32'(Swap_Pending), 32'(m_pend));
`ifdef VGA_ARB_STATS_EN
         chk("stall_cycles", 32'(Wr_Stall_Cycles), 32'(m_cnt));
`endif
         if (rst_q) begin
            chk("rst_mem_en", 32'(Mem_En), 32'd0);
            chk("rst_mem_we", 32'(Mem_WE), 32'd0);
            chk("rst_mem_addr", 32'(Mem_Addr), 32'd0);
            chk("rst_mem_wdata", 32'(Mem_WData), 32'd0);
            chk("rst_disp_valid", 32'(Disp_Valid), 32'd0);
         end
         if (Mem_En) begin
            if (cmd_q.size() == 0) begin
               chk("unexpected_cmd", 32'(Mem_Addr), 32'hFFFFFFFF);
            end else begin
               c = cmd_q.pop_front();
               chk("cmd_cycle", 32'(cyc), 32'(c.cyc));
               chk("cmd_we", 32'(Mem_WE), 32'(c.we));
               chk("cmd_addr", 32'(Mem_Addr), 32'(c.addr));
               if (c.we) chk("cmd_wdata", 32'(Mem_WData), 32'(c.wdata));
            end
         end
         while (cmd_q.size() > 0 && cmd_q[0].cyc < cyc) begin
            c = cmd_q.pop_front();
            chk("missing_cmd", 32'(cyc), 32'(c.cyc));
         end
         if (Disp_Valid) begin
            if (rd_q.size() == 0) begin
               chk("unexpected_valid", 32'(Disp_Data), 32'hFFFFFFFF);
            end else begin
               r = rd_q.pop_front();
               chk("rd_cycle", 32'(cyc), 32'(r.cyc));
               chk("rd_data", 32'(Disp_Data), 32'(r.data));
            end
         end
         while (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
            r = rd_q.pop_front();
            chk("missing_valid", 32'(cyc), 32'(r.cyc));
         end
      end
   end

   // Drive one cycle of stimulus and push what the arbiter must do with it
   task automatic drive(input logic dreq, input logic [ADDR_W-1:0] daddr,
                        input logic wreq, input logic [ADDR_W-1:0] waddr, input logic [7:0] wdata,
                        input logic swap, input logic vb, input logic rst);
      cmd_t c;
      rd_t  r;
      int   k;
      @(posedge CLK);
      #1;
      m_front = n_front;
      m_pend  = n_pend;
      m_cnt   = n_cnt;
      RST = rst; Disp_Req = dreq; Disp_Addr = daddr;
      Wr_Req = wreq; Wr_Addr = waddr; Wr_Data = wdata;
      Swap_Req = swap; VBlank_Start = vb;
      if (rst) begin
         exp_ack = 1'b0;
         for (int i = cmd_q.size() - 1; i >= 0; i--) if (cmd_q[i].cyc > cyc) cmd_q.delete(i);
         for (int i = rd_q.size() - 1; i >= 0; i--) if (rd_q[i].cyc > cyc) rd_q.delete(i);
         n_front = 1'b0; n_pend = 1'b0; n_cnt = 0;
      end else begin
         exp_ack = 1'b0;
         if (dreq) begin
            c.cyc = cyc + 1; c.we = 1'b0; c.addr = {m_front, daddr}; c.wdata = 8'h00;
            cmd_q.push_back(c);
            k = int'(c.addr);
            r.cyc  = cyc + 1 + LAT;
            r.data = exp_mem.exists(k) ? exp_mem[k] : init_val(c.addr);
            rd_q.push_back(r);
         end else if (wreq) begin
            exp_ack = 1'b1;
            c.cyc = cyc + 1; c.we = 1'b1; c.addr = {~m_front, waddr}; c.wdata = wdata;
            cmd_q.push_back(c);
            exp_mem[int'(c.addr)] = wdata;
         end
         if (vb && (m_pend || swap)) begin
            n_front = ~m_front; n_pend = 1'b0;
         end else if (swap) begin
            n_pend = 1'b1;
         end
         if (vb) n_cnt = 0;
         else if (wreq && !exp_ack && m_cnt != 65535) n_cnt = m_cnt + 1;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, '0, 1'b0, '0, 8'h00, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout want finish at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic              w_pend;
      logic [ADDR_W-1:0] w_a;
      logic [7:0]        w_d;
      RST = 1'b1; Disp_Req = 1'b0; Disp_Addr = '0; Wr_Req = 1'b0; Wr_Addr = '0;
      Wr_Data = '0; Swap_Req = 1'b0; VBlank_Start = 1'b0;
      drive(1'b0, '0, 1'b0, '0, 8'h00, 1'b0, 1'b0, 1'b1);
      drive(1'b0, '0, 1'b0, '0, 8'h00, 1'b0, 1'b0, 1'b1);
      mon_en = 1'b1;

      // Read latency from front bank 0
      drive(1'b1, 19'd5, 1'b0, '0, 8'h00, 1'b0, 1'b0, 1'b0);
      idle(3);

      // Write stalled by 8 display cycles, then acked into bank 1
      repeat (8) drive(1'b1, ADDR_W'($urandom_range(63)), 1'b1, 19'h10, 8'hAB, 1'b0, 1'b0, 1'b0);
      drive(1'b0, '0, 1'b1, 19'h10, 8'hAB, 1'b0, 1'b0, 1'b0);
      idle(3);

      // Deferred swap, then writes land in bank 0
      drive(1'b0, '0, 1'b0, '0, 8'h00, 1'b1, 1'b0, 1'b0);
      idle(100);
      drive(1'b0, '0, 1'b0, '0, 8'h00, 1'b0, 1'b1, 1'b0);
      drive(1'b0, '0, 1'b1, 19'h21, 8'h3C, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 19'h10, 1'b1, 19'h22, 8'h3D, 1'b0, 1'b0, 1'b0);
      idle(3);

      // Simultaneous swap+vblank, double request, vblank with nothing pending
      drive(1'b0, '0, 1'b0, '0, 8'h00, 1'b1, 1'b1, 1'b0);
      idle(2);
      drive(1'b0, '0, 1'b0, '0, 8'h00, 1'b1, 1'b0, 1'b0);
      drive(1'b0, '0, 1'b0, '0, 8'h00, 1'b1, 1'b0, 1'b0);
      drive(1'b0, '0, 1'b1, 19'h30, 8'h77, 1'b0, 1'b1, 1'b0);
      drive(1'b0, '0, 1'b1, 19'h31, 8'h78, 1'b0, 1'b1, 1'b0);
      idle(2);

      // Reset one cycle after a read grant flushes it and restores bank 0
      drive(1'b1, 19'h21, 1'b0, '0, 8'h00, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 19'h22, 1'b1, 19'h5, 8'h11, 1'b0, 1'b0, 1'b1);
      drive(1'b0, '0, 1'b0, '0, 8'h00, 1'b0, 1'b0, 1'b1);
      idle(4);

      // Four back-to-back writes with the display idle
      for (int i = 0; i < 4; i++)
         drive(1'b0, '0, 1'b1, ADDR_W'(19'h40 + i), 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++)
         drive(1'b1, ADDR_W'(19'h40 + i), 1'b0, '0, 8'h00, 1'b0, 1'b0, 1'b0);
      idle(3);

      // Randomized traffic with a writer that holds its request until acked
      w_pend = 1'b0; w_a = '0; w_d = '0;
      for (int n = 0; n < 2000; n++) begin
         if (!w_pend && $urandom_range(99) < 60) begin
            w_pend = 1'b1;
            w_a = ADDR_W'($urandom_range(63));
            w_d = 8'($urandom);
         end
         drive($urandom_range(99) < 45, ADDR_W'($urandom_range(63)), w_pend, w_a, w_d,
               $urandom_range(99) < 3, $urandom_range(99) < 2, $urandom_range(999) < 5);
         if (exp_ack) w_pend = 1'b0;
      end

      idle(LAT + 4);
      chk("cmd_queue_empty", 32'(cmd_q.size()), 32'd0);
      chk("rd_queue_empty", 32'(rd_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
